// File: rtl/alu_pwr_ctrl.sv
// ---------------------------------------------------------------------------
// alu_pwr_ctrl
//   Power-sequencing controller for the ALU power domain. Turns single-cycle
//   power-up / power-down requests into ordered sequences:
//     power-up   : power on -> release domain reset -> remove isolation
//     power-down : drain in-flight work -> isolate -> power off
//
// Ports
//   clk           single clock
//   rst           asynchronous active-high reset
//   pwr_up_req    single-cycle request to power the ALU up
//   pwr_down_req  single-cycle request to power the ALU down
//   alu_busy      ALU operation in flight (only looked at while draining)
//   alu_pwr_en    ALU domain power enable (registered)
//   iso_en        ALU output isolation, 1 = isolated (registered)
//   alu_rst_n     ALU domain reset, active-low (registered)
//   pwr_state     current state encoding
//   pwr_done      one-cycle pulse on entering ON or OFF through a sequence
//   req_drop      one-cycle pulse when a request is ignored
//   drain_to      one-cycle pulse when the drain timeout forces power-down
// ---------------------------------------------------------------------------
module alu_pwr_ctrl #(
  parameter int PWR_UP_CYCLES    = 4,
  parameter int RST_REL_CYCLES   = 2,
  parameter int ISO_SETUP_CYCLES = 2,
  parameter int DRAIN_TIMEOUT    = 16,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pwr_up_req,
  input  logic       pwr_down_req,
  input  logic       alu_busy,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       alu_rst_n,
  output logic [2:0] pwr_state,
  output logic       pwr_done,
  output logic       req_drop,
  output logic       drain_to
);

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    PU_RAMP  = 3'd1,
    PU_RST   = 3'd2,
    ON       = 3'd3,
    PD_DRAIN = 3'd4,
    PD_ISO   = 3'd5
  } state_t;

  // The counter starts at 0 on state entry, so a state lasting N cycles
  // leaves when the counter reads N-1.
  localparam int DRAIN_LAST_I = (DRAIN_TIMEOUT == 0) ? 0 : DRAIN_TIMEOUT - 1;
  localparam logic [CNT_W-1:0] PU_LAST    = CNT_W'(PWR_UP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_REL_CYCLES - 1);
  localparam logic [CNT_W-1:0] ISO_LAST   = CNT_W'(ISO_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LAST_I);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             pwr_en_nx;
  logic             iso_nx;
  logic             rst_n_nx;
  logic             done_nx;
  logic             drop_nx;
  logic             dto_nx;

  // State register. Control outputs are registered from the next-state decode
  // so they change exactly with the state and never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= OFF;
      cnt        <= '0;
      alu_pwr_en <= 1'b0;
      iso_en     <= 1'b1;
      alu_rst_n  <= 1'b0;
      pwr_done   <= 1'b0;
      req_drop   <= 1'b0;
      drain_to   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      alu_pwr_en <= pwr_en_nx;
      iso_en     <= iso_nx;
      alu_rst_n  <= rst_n_nx;
      pwr_done   <= done_nx;
      req_drop   <= drop_nx;
      drain_to   <= dto_nx;
    end
  end

  // Next-state, pulse and output decode. Requests are only honoured in the
  // two stable states; anything else is dropped and never queued. Unused
  // encodings fall back to OFF, the safe isolated/unpowered state.
  always_comb begin
    state_nx  = state;
    done_nx   = 1'b0;
    drop_nx   = 1'b0;
    dto_nx    = 1'b0;
    cnt_nx    = '0;
    pwr_en_nx = 1'b0;
    iso_nx    = 1'b1;
    rst_n_nx  = 1'b0;

    case (state)
      OFF: begin
        drop_nx = pwr_down_req;
        if (pwr_up_req) state_nx = PU_RAMP;
      end
      PU_RAMP: begin
        drop_nx = pwr_up_req | pwr_down_req;
        if (cnt == PU_LAST) state_nx = PU_RST;
      end
      PU_RST: begin
        drop_nx = pwr_up_req | pwr_down_req;
        if (cnt == RST_LAST) begin
          state_nx = ON;
          done_nx  = 1'b1;
        end
      end
      ON: begin
        drop_nx = pwr_up_req;
        if (pwr_down_req) state_nx = PD_DRAIN;
      end
      PD_DRAIN: begin
        drop_nx = pwr_up_req | pwr_down_req;
        // An idle ALU wins over a timeout expiring in the same cycle.
        if (!alu_busy) begin
          state_nx = PD_ISO;
        end else if ((DRAIN_TIMEOUT != 0) && (cnt == DRAIN_LAST)) begin
          state_nx = PD_ISO;
          dto_nx   = 1'b1;
        end
      end
      PD_ISO: begin
        drop_nx = pwr_up_req | pwr_down_req;
        if (cnt == ISO_LAST) begin
          state_nx = OFF;
          done_nx  = 1'b1;
        end
      end
      default: begin
        state_nx = OFF;
      end
    endcase

    // Shared saturating counter, cleared whenever the state changes.
    if (state_nx != state) begin
      cnt_nx = '0;
    end else if (cnt == {CNT_W{1'b1}}) begin
      cnt_nx = cnt;
    end else begin
      cnt_nx = cnt + 1'b1;
    end

    // Isolation stays on whenever power or domain reset is not fully up.
    case (state_nx)
      PU_RAMP:  begin pwr_en_nx = 1'b1; iso_nx = 1'b1; rst_n_nx = 1'b0; end
      PU_RST:   begin pwr_en_nx = 1'b1; iso_nx = 1'b1; rst_n_nx = 1'b1; end
      ON:       begin pwr_en_nx = 1'b1; iso_nx = 1'b0; rst_n_nx = 1'b1; end
      PD_DRAIN: begin pwr_en_nx = 1'b1; iso_nx = 1'b0; rst_n_nx = 1'b1; end
      PD_ISO:   begin pwr_en_nx = 1'b1; iso_nx = 1'b1; rst_n_nx = 1'b1; end
      default:  begin pwr_en_nx = 1'b0; iso_nx = 1'b1; rst_n_nx = 1'b0; end
    endcase
  end

  assign pwr_state = state;

endmodule
